nyq_interp: RTL and testbench
=============================

# nyq_interp

Polyphase interpolation filter on the transmit side of the sample chain, the counterpart of the Nyquist decimator. Each accepted input sample expands into `L = 8` output samples. The block low-pass filters the zero-stuffed stream with a 32-tap FIR. Coefficients come from the standard externally written parameter memory, and samples move through valid/ready handshakes on both sides.

## Interface
- `ADDR_WIDTH`, 9, parameter address width (common to all blocks)
- `MEM_WIDTH`, 32, parameter word width (common)
- `IN_WIDTH`, 24, signed input sample width
- `OUT_WIDTH`, 24, signed output sample width
- `COEFF_WIDTH`, 24, signed coefficient width, held in `PAR_In_DI[COEFF_WIDTH-1:0]`
- `COEFF_FRAC`, 22, coefficient fractional bits (`0x400000` = 1.0)
- `Clk_CI`  in  1  single clock; everything is on its rising edge
- `Rst_RI`  in  1  reset, asynchronous and active-high
- `WrEn_SI`  in  1  parameter write enable, active high
- `Addr_DI`  in  `ADDR_WIDTH`  parameter address
- `PAR_In_DI`  in  `MEM_WIDTH`  parameter data
- `In_DI`  in  `IN_WIDTH`  signed input sample
- `In_Valid_SI`  in  1  input sample valid
- `In_Ready_SO`  out  1  block can accept an input
- `Out_DO`  out  `OUT_WIDTH`  signed interpolated sample
- `Out_Valid_SO`  out  1  `Out_DO` valid
- `Out_Ready_SI`  in  1  downstream accepts `Out_DO`

## Operation
- **Coefficient memory**
  - 32 entries `h[0..31]`, each `COEFF_WIDTH` bits.
  - A write with `WrEn_SI` and `Addr_DI < 32` updates `h[Addr_DI]` at the edge.
  - Writes to addresses `>= 32` are dropped.
  - Reads are combinational, so a write takes effect on the next phase computed, including mid-burst.
- **Delay line**
  - Four signed registers `x0..x3`, where `x0` is the newest sample.
  - On input acceptance (`In_Valid_SI & In_Ready_SO` at an edge) the line shifts and `x0 <= In_DI`.
- **Phase output**
  - Phase `p` (0..7) computes `y_p = sum_{j=0..3} h[p+8j] * x_j`.
  - Products are 48 bits; the sum is formed at 50 bits.
  - The result is shifted right arithmetically by `COEFF_FRAC`, i.e. floor/truncate.
  - The result is then saturated to `OUT_WIDTH`: `0x7FFFFF` / `0x800000`.
  - Filter gain, including the factor L, is set by the coefficients only.
- **FSM**
  - States are `IDLE` and `RUN`, plus a 3-bit phase counter `ph`.
  - `IDLE`: `In_Ready_SO = 1`. On acceptance go to `RUN` with `ph = 0`.
  - `RUN`: `In_Ready_SO = 0`.
    - When the output register is free (`!Out_Valid_SO | Out_Ready_SI`), load `y_ph`, set `Out_Valid_SO`, and increment `ph`.
    - After loading `ph = 7`, go to `IDLE`.
- **Output register**
  - When `Out_Valid_SO & Out_Ready_SI` and nothing new is loaded, `Out_Valid_SO` falls.
  - While `Out_Valid_SO & !Out_Ready_SI`, `Out_DO` holds its value and no phase is skipped or repeated.
- **Reset** (asynchronous, any time including mid-burst) clears:
  - all 32 coefficients and `x0..x3`
  - `ph = 0`, state `IDLE`
  - `Out_DO = 0`, `Out_Valid_SO = 0`
  - `In_Ready_SO = 1` once reset is released; it is also 1 while reset is held, as it is combinational from `IDLE`.
  - A burst interrupted by reset is discarded; the first input after reset starts a fresh burst at phase 0.

## Timing
- **Acceptance edge E0:** the delay line is updated.
- **Edge E1:** phase 0 is loaded; `Out_Valid_SO` is high after E1.
- **With `Out_Ready_SI` held high:** phase k appears after E1+k, and phase 7 after E8.
- **Return to `IDLE`:** the block is in `IDLE` after E8, so the next acceptance is at E9 at the earliest.
  - Phase 0 of the next sample loads at E10.
  - This leaves one bubble cycle (`Out_Valid_SO = 0` between E9 and E10).
- **Throughput:** one input per 9 cycles, exactly 8 outputs per input.
- **Backpressure:** stretches `RUN` one cycle per stalled cycle; `In_Ready_SO` stays low throughout.
- **Simultaneous parameter write and phase load at the same edge:** the load uses the old coefficient.

## Structure
- **Shared package `nyq_pkg`:** `L = 8`, `TAPS_PER_PHASE = 4`, `NUM_TAPS = 32`, `COEFF_FRAC` default, and the FSM state encoding (`IDLE`, `RUN`).
- **One sub-module `nyq_interp_dot4`:** combinational.
  - Inputs: four samples and four coefficients.
  - Performs the 50-bit sum, arithmetic shift, and saturation; output is `OUT_WIDTH` bits.
  - The top level holds the memory, delay line, FSM and output register.

## Test plan
- **Reset:** assert `Rst_RI` mid-sim with no clock edge -> immediately `Out_DO = 0`, `Out_Valid_SO = 0`; `In_Ready_SO = 1` after release.
- **Impulse / coefficient mapping:**
  - Stimulus: `h[k] = k << 16` for k=0..31; inputs 64, 0, 0, 0 with `Out_Ready_SI = 1`.
  - Required response: 32 outputs equal to 0, 1, 2, ..., 31 in order.
- **Saturation:**
  - All `h = 0x400000`; four inputs of `0x7FFFFF` -> the final burst is all `0x7FFFFF`.
  - Repeat with four inputs of `0x800000` -> all `0x800000`.
- **Backpressure:**
  - Stimulus: same setup as the impulse test; drop `Out_Ready_SI` for 5 cycles while phase 3 is presented.
  - Required response: `Out_DO` holds 3 and `In_Ready_SO` stays 0; the sequence resumes at 4 with no loss or duplicate.
- **Throughput:**
  - Stimulus: `In_Valid_SI` and `Out_Ready_SI` held high.
  - Required response: acceptances exactly 9 cycles apart, 8 valid outputs per acceptance, one bubble between bursts.
- **Reset mid-burst:** assert reset after phase 4 of a burst -> the burst is aborted and all coefficients read 0, so the next burst outputs all 0 until coefficients are rewritten.

Source files
------------

// File: rtl/nyq_pkg.sv
// Shared constants and FSM encoding for the Nyquist interpolator.
package nyq_pkg;
    localparam int L               = 8;
    localparam int TAPS_PER_PHASE  = 4;
    localparam int NUM_TAPS        = 32;
    localparam int COEFF_FRAC_DFLT = 22;
    localparam int PH_W            = $clog2(L);
    localparam int TAP_W           = $clog2(NUM_TAPS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/nyq_interp_dot4.sv
// Combinational 4-term dot product with floor shift and saturation to OUT_WIDTH.
module nyq_interp_dot4
    import nyq_pkg::*;
#(
    parameter int IN_WIDTH    = 24,
    parameter int OUT_WIDTH   = 24,
    parameter int COEFF_WIDTH = 24,
    parameter int COEFF_FRAC  = COEFF_FRAC_DFLT
) (
    input  logic signed [IN_WIDTH-1:0]    x_i [TAPS_PER_PHASE],
    input  logic signed [COEFF_WIDTH-1:0] h_i [TAPS_PER_PHASE],
    output logic signed [OUT_WIDTH-1:0]   y_o
);
    localparam int PROD_W = IN_WIDTH + COEFF_WIDTH;
    localparam int SUM_W  = PROD_W + 2;

    localparam logic signed [SUM_W-1:0] MAX_V =
        {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V =
        {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [PROD_W-1:0] prod [TAPS_PER_PHASE];
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;

    always_comb begin
        sum = '0;
        for (int j = 0; j < TAPS_PER_PHASE; j++) begin
            prod[j] = PROD_W'(x_i[j]) * PROD_W'(h_i[j]);
            sum     = sum + SUM_W'(prod[j]);
        end
        shifted = sum >>> COEFF_FRAC;
    end

    always_comb begin
        if (shifted > MAX_V) begin
            y_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (shifted < MIN_V) begin
            y_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            y_o = shifted[OUT_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/nyq_interp.sv
// Polyphase x8 interpolator: each accepted sample yields 8 FIR phases, one per free output slot.
// Input is accepted only in IDLE; output stalls hold Out_DO and stretch the burst.
module nyq_interp
    import nyq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int MEM_WIDTH   = 32,
    parameter int IN_WIDTH    = 24,
    parameter int OUT_WIDTH   = 24,
    parameter int COEFF_WIDTH = 24,
    parameter int COEFF_FRAC  = COEFF_FRAC_DFLT
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic [IN_WIDTH-1:0]   In_DI,
    input  logic                  In_Valid_SI,
    output logic                  In_Ready_SO,
    output logic [OUT_WIDTH-1:0]  Out_DO,
    output logic                  Out_Valid_SO,
    input  logic                  Out_Ready_SI
);
    logic signed [COEFF_WIDTH-1:0] coef_q   [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0] coef_sel [TAPS_PER_PHASE];
    logic signed [IN_WIDTH-1:0]    dly_q    [TAPS_PER_PHASE];

    state_e                      state_q, state_d;
    logic [PH_W-1:0]             ph_q, ph_d;
    logic                        out_vld_q, out_vld_d;
    logic signed [OUT_WIDTH-1:0] out_dat_q, out_dat_d;
    logic signed [OUT_WIDTH-1:0] phase_y;
    logic                        in_rdy, accept, load, addr_ok;
    logic                        unused_par;

    assign unused_par = ^PAR_In_DI[MEM_WIDTH-1:COEFF_WIDTH];
    assign addr_ok    = (Addr_DI < ADDR_WIDTH'(NUM_TAPS));
    assign accept     = In_Valid_SI & in_rdy;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= '0;
        end else if (WrEn_SI && addr_ok) begin
            coef_q[Addr_DI[TAP_W-1:0]] <= PAR_In_DI[COEFF_WIDTH-1:0];
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            for (int i = 0; i < TAPS_PER_PHASE; i++) dly_q[i] <= '0;
        end else if (accept) begin
            dly_q[0] <= In_DI;
            for (int i = 1; i < TAPS_PER_PHASE; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    // Phase p uses taps p, p+8, p+16, p+24 against x0..x3.
    always_comb begin
        for (int j = 0; j < TAPS_PER_PHASE; j++) begin
            coef_sel[j] = coef_q[TAP_W'(j * L) + TAP_W'(ph_q)];
        end
    end

    nyq_interp_dot4 #(
        .IN_WIDTH    (IN_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .COEFF_FRAC  (COEFF_FRAC)
    ) u_dot4 (
        .x_i (dly_q),
        .h_i (coef_sel),
        .y_o (phase_y)
    );

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        in_rdy    = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
                if (In_Valid_SI) begin
                    state_d = RUN;
                    ph_d    = '0;
                end
            end
            RUN: begin
                if (!out_vld_q || Out_Ready_SI) begin
                    load      = 1'b1;
                    out_dat_d = phase_y;
                    out_vld_d = 1'b1;
                    ph_d      = ph_q + 1'b1;
                    if (ph_q == PH_W'(L - 1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!load && out_vld_q && Out_Ready_SI) out_vld_d = 1'b0;
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    assign In_Ready_SO  = in_rdy;
    assign Out_DO       = out_dat_q;
    assign Out_Valid_SO = out_vld_q;
endmodule

// File: tb/tb_nyq_interp.sv
// Scoreboard bench for nyq_interp: model results queued on acceptance, compared on output handshake.
module tb_nyq_interp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] par = '0;
    logic [23:0] in_dat = '0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [23:0] out_dat;
    logic        out_vld;
    logic        out_rdy = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int last_acc = 0;
    int outs_since_acc = 0;
    bit tput_mode = 1'b0;
    bit tput_prev = 1'b0;
    bit bubble_pend = 1'b0;
    logic [23:0] last_out = '0;

    logic signed [23:0] h_m [32];
    logic signed [23:0] x_m [4];
    logic [23:0] sb [$];

    nyq_interp dut (
        .Clk_CI       (clk),
        .Rst_RI       (rst),
        .WrEn_SI      (wr_en),
        .Addr_DI      (addr),
        .PAR_In_DI    (par),
        .In_DI        (in_dat),
        .In_Valid_SI  (in_vld),
        .In_Ready_SO  (in_rdy),
        .Out_DO       (out_dat),
        .Out_Valid_SO (out_vld),
        .Out_Ready_SI (out_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_y(input int p);
        longint s = 0;
        for (int j = 0; j < 4; j++) s += longint'(h_m[p + 8*j]) * longint'(x_m[j]);
        s = s >>> 22;
        if (s > 64'sd8388607)  return 24'h7FFFFF;
        if (s < -64'sd8388608) return 24'h800000;
        return s[23:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) h_m[i] = '0;
        for (int i = 0; i < 4; i++) x_m[i] = '0;
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bubble_pend) begin
                chk("bubble", {31'd0, out_vld}, 32'd0);
                bubble_pend = 1'b0;
            end
            if (out_vld && out_rdy) begin
                if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
                else chk("out", {8'd0, out_dat}, {8'd0, sb.pop_front()});
                last_out = out_dat;
                outs_since_acc++;
            end
            if (in_vld && in_rdy) begin
                if (tput_mode && tput_prev) begin
                    chk("accept_gap", cyc - last_acc, 32'd9);
                    chk("outs_per_accept", outs_since_acc, 32'd8);
                    bubble_pend = 1'b1;
                end
                if (tput_mode) tput_prev = 1'b1;
                last_acc = cyc;
                outs_since_acc = 0;
                acc_cnt++;
                for (int i = 3; i > 0; i--) x_m[i] = x_m[i-1];
                x_m[0] = in_dat;
                for (int p = 0; p < 8; p++) sb.push_back(model_y(p));
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic write_coef(input int a, input logic [31:0] d);
        wr_en = 1'b1; addr = 9'(a); par = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (a < 32) h_m[a] = d[23:0];
    endtask

    task automatic send(input logic [23:0] v);
        int a0;
        int n;
        a0 = acc_cnt; n = 0;
        in_dat = v; in_vld = 1'b1;
        while (acc_cnt == a0 && n < 100) begin
            @(posedge clk); n++;
        end
        if (acc_cnt == a0) chk("accept_timeout", 32'd0, 32'd1);
        if (n == 0) @(posedge clk);
        #1 in_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_vld) && n < 400) begin
            @(posedge clk); n++;
        end
        #1 chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        int n;
        int a0;
        model_clear();
        #1;
        chk("rst_out_dat", {8'd0, out_dat}, 32'd0);
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_in_rdy",  {31'd0, in_rdy},  32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_in_rdy", {31'd0, in_rdy}, 32'd1);

        // Impulse: h[k] = k<<16, input 64 then zeros -> 0..31
        for (int k = 0; k < 32; k++) write_coef(k, 32'(k) << 16);
        send(24'd64); send(24'd0); send(24'd0); send(24'd0);
        wait_drain();
        chk("imp_last", {8'd0, last_out}, 32'd31);

        // Backpressure on phase 3
        send(24'd64);
        n = 0;
        while (!(out_vld && out_dat == 24'd3) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_reach_ph3", {8'd0, out_dat}, 32'd3);
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_dat", {8'd0, out_dat}, 32'd3);
            chk("bp_hold_vld", {31'd0, out_vld}, 32'd1);
            chk("bp_in_rdy",   {31'd0, in_rdy},  32'd0);
        end
        @(posedge clk); #1 out_rdy = 1'b1;
        wait_drain();
        chk("bp_last", {8'd0, last_out}, 32'd7);

        // Throughput with random samples
        tput_mode = 1'b1; tput_prev = 1'b0;
        a0 = acc_cnt; n = 0;
        in_vld = 1'b1;
        while (acc_cnt < a0 + 4 && n < 200) begin
            in_dat = 24'($urandom_range(0, 4000));
            @(posedge clk); #1; n++;
        end
        in_vld = 1'b0;
        chk("tput_accepts", acc_cnt - a0, 32'd4);
        wait_drain();
        tput_mode = 1'b0;

        // Saturation, positive then negative
        for (int k = 0; k < 32; k++) write_coef(k, 32'h400000);
        for (int i = 0; i < 4; i++) send(24'h7FFFFF);
        wait_drain();
        chk("sat_pos", {8'd0, last_out}, 32'h7FFFFF);
        for (int i = 0; i < 4; i++) send(24'h800000);
        wait_drain();
        chk("sat_neg", {8'd0, last_out}, 32'h800000);

        // Reset mid-burst, applied between edges
        for (int k = 0; k < 32; k++) write_coef(k, 32'(k) << 16);
        send(24'd0); send(24'd0); send(24'd0);
        wait_drain();
        send(24'd64);
        n = 0;
        while (!(out_vld && out_dat == 24'd4) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("mid_reach_ph4", {8'd0, out_dat}, 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_dat", {8'd0, out_dat}, 32'd0);
        chk("mid_rst_vld", {31'd0, out_vld}, 32'd0);
        chk("mid_rst_rdy", {31'd0, in_rdy},  32'd1);
        model_clear();
        @(posedge clk); #1 rst = 1'b0;
        chk("mid_rel_rdy", {31'd0, in_rdy}, 32'd1);
        send(24'd100);
        wait_drain();
        chk("post_rst_zero", {8'd0, last_out}, 32'd0);

        // Out-of-range writes must be dropped
        write_coef(32, 32'h400000);
        write_coef(40, 32'h123456);
        write_coef(0, 32'h400000);
        send(24'd5);
        wait_drain();
        chk("oob_last", {8'd0, last_out}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
